pipelined_carry_adder: RTL and testbench

Parametrised, pipelined successor to the 32-bit ripple carry adder. Splits a WIDTH-bit add/subtract into STAGES ripple segments separated by registers, with one segment resolved per cycle and the carry passed between stages. A valid/ready handshake on both sides sustains one operation per cycle. Outputs are carry-out and signed overflow. Sits in the datapath wherever a full-width adder exceeds one cycle of ripple delay.

---
 rtl/pipelined_carry_adder.sv | 141 ++++++++++++++
 tb/tb_pipelined_carry_adder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into STAGES ripple
// segments. Stage k resolves bits [k*SEG +: SEG] and passes its carry on.
// A single global advance moves or holds the whole pipeline. One beat per
// cycle is sustained while the consumer is ready.
module pipelined_carry_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             of
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned SEGW = SEG + 1;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage pipeline registers: valid, operands, partial sum, carry
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             of_q;
  logic             of_d;

  // Source feeding each stage: the input port for stage 0, else the previous stage
  logic             prev_v [STAGES];
  logic [WIDTH-1:0] prev_a [STAGES];
  logic [WIDTH-1:0] prev_b [STAGES];
  logic [WIDTH-1:0] prev_s [STAGES];
  logic             prev_c [STAGES];

  logic adv;

  // Whole pipeline moves unless the output holds a beat the consumer refuses
  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  // Result ports come straight from the last stage registers
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = c_q[LAST];
  assign of        = of_q;

  // Select each stage's predecessor; subtraction inverts B and forces carry-in
  always_comb begin
    prev_v[0] = in_valid;
    prev_a[0] = in1;
    prev_b[0] = sub ? ~in2 : in2;
    prev_s[0] = '0;
    prev_c[0] = sub ? 1'b1 : c_in;
    for (int k = 1; k < STAGES; k++) begin
      prev_v[k] = v_q[k-1];
      prev_a[k] = a_q[k-1];
      prev_b[k] = b_q[k-1];
      prev_s[k] = s_q[k-1];
      prev_c[k] = c_q[k-1];
    end
  end

  // Next state: hold by default, on advance each stage ripples its own segment
  always_comb begin
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic [SEG:0]   seg_r;
    logic           msb_cin;

    a_seg   = '0;
    b_seg   = '0;
    seg_r   = '0;
    msb_cin = 1'b0;
    of_d    = of_q;
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
    end

    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_seg   = prev_a[k][k*SEG +: SEG];
        b_seg   = prev_b[k][k*SEG +: SEG];
        seg_r   = {1'b0, a_seg} + {1'b0, b_seg} + SEGW'(prev_c[k]);
        // Carry into the segment's top bit, recovered from its sum bit
        msb_cin = seg_r[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1];

        v_d[k] = prev_v[k];
        a_d[k] = prev_a[k];
        b_d[k] = prev_b[k];
        s_d[k] = prev_s[k];
        s_d[k][k*SEG +: SEG] = seg_r[SEG-1:0];
        c_d[k] = seg_r[SEG];
        if (k == LAST) begin
          of_d = msb_cin ^ seg_r[SEG];
        end
      end
    end
  end

  // Stage registers with synchronous reset that discards every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      of_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      of_q <= of_d;
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder: a driver pushes expected results
// on acceptance, a monitor pops and compares whenever a result is consumed.
module tb_pipelined_carry_adder;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 4;
  localparam int unsigned W1 = W + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ov;
    int           acc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] s;
    logic         c;
    logic         ov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, c_in, sub;
  logic         out_valid, out_ready, c_out, of_o;
  logic [W-1:0] in1, in2, sum;

  logic       v8_iv, v8_ir, v8_ci, v8_sub, v8_ov, v8_or, v8_co, v8_of;
  logic [7:0] v8_a, v8_b, v8_s;

  logic        w16_iv, w16_ir, w16_ci, w16_sub, w16_ov, w16_or, w16_co, w16_of;
  logic [15:0] w16_a, w16_b, w16_s;

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .of(of_o)
  );

  pipelined_carry_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8_iv), .in_ready(v8_ir),
    .in1(v8_a), .in2(v8_b), .c_in(v8_ci), .sub(v8_sub),
    .out_valid(v8_ov), .out_ready(v8_or),
    .sum(v8_s), .c_out(v8_co), .of(v8_of)
  );

  pipelined_carry_adder #(.WIDTH(16), .STAGES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w16_iv), .in_ready(w16_ir),
    .in1(w16_a), .in2(w16_b), .c_in(w16_ci), .sub(w16_sub),
    .out_valid(w16_ov), .out_ready(w16_or),
    .sum(w16_s), .c_out(w16_co), .of(w16_of)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rand_ready = 1'b0;

  // Cycle index: a beat offered while cyc=N is captured by the edge that makes cyc=N+1
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, overflow = signed result out of range
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint sa, sbv, r;
    logic [W:0] u;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      r     = sa - sbv;
      e.sum = W'(a - b);
      e.c   = (a >= b);
    end else begin
      u     = {1'b0, a} + {1'b0, b} + W1'(ci);
      r     = sa + sbv + longint'(ci);
      e.sum = u[W-1:0];
      e.c   = u[W];
    end
    e.ov  = (r > 64'sh7FFF_FFFF) || (r < -(64'sh8000_0000));
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Drive one cycle of input; on transfer push the expected result
  task automatic offer(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb, input bit use_tbl,
                       input exp_t tbl, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in1      = a;
    in2      = b;
    c_in     = ci;
    sub      = sb;
    #1;
    acc = v && in_ready && !rst;
    if (acc) begin
      e     = use_tbl ? tbl : model(a, b, ci, sb);
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  // Monitor: randomise consumer readiness, check stability while stalled, pop on transfer
  initial begin
    logic         stalled;
    logic [W-1:0] ps;
    logic         pc, po;
    exp_t         e;
    stalled   = 1'b0;
    ps        = '0;
    pc        = 1'b0;
    po        = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_sum", 64'(sum), 64'(ps));
          chk("stall_c_out", 64'(c_out), 64'(pc));
          chk("stall_of", 64'(of_o), 64'(po));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got sum 0x%0h with nothing outstanding", sum);
          end else begin
            e = q.pop_front();
            chk("sum", 64'(sum), 64'(e.sum));
            chk("c_out", 64'(c_out), 64'(e.c));
            chk("of", 64'(of_o), 64'(e.ov));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(S));
          end
        end
        stalled = out_valid && !out_ready;
        ps      = sum;
        pc      = c_out;
        po      = of_o;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence
  initial begin
    vec_t dv[7];
    exp_t dummy;
    exp_t t;
    bit   acc;
    int   nacc;
    int   n;

    dummy = '{sum: '0, c: 1'b0, ov: 1'b0, acc: 0, lat: 1'b0};
    dv[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    dv[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    dv[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
    dv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    dv[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    dv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    dv[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; c_in = 1'b0; sub = 1'b0;
    v8_iv = 1'b0; v8_a = '0; v8_b = '0; v8_ci = 1'b0; v8_sub = 1'b0; v8_or = 1'b1;
    w16_iv = 1'b0; w16_a = '0; w16_b = '0; w16_ci = 1'b0; w16_sub = 1'b0; w16_or = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_of", 64'(of_o), 64'd0);
    chk("rst_v8_valid", 64'(v8_ov), 64'd0);
    chk("rst_w16_valid", 64'(w16_ov), 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Directed vectors, back to back, consumer always ready
    foreach (dv[i]) begin
      t     = dummy;
      t.sum = dv[i].s;
      t.c   = dv[i].c;
      t.ov  = dv[i].ov;
      offer(1'b1, dv[i].a, dv[i].b, dv[i].ci, dv[i].sb, 1'b1, t, 1'b1, acc);
      chk("directed_accept", 64'(acc), 64'd1);
    end
    offer(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, dummy, 1'b0, acc);
    wait_drain("directed_drain");

    // Random streaming with random valid and ready
    rand_ready = 1'b1;
    nacc = 0;
    for (int i = 0; i < 5000 && nacc < 200; i++) begin
      offer(($urandom_range(0, 99) < 70), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, dummy, 1'b0, acc);
      if (acc) nacc++;
    end
    chk("random_accepted", 64'(nacc), 64'd200);
    offer(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, dummy, 1'b0, acc);
    rand_ready = 1'b0;
    wait_drain("random_drain");

    // Reset mid-flight discards accepted beats
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, dummy, 1'b0, acc);
      chk("flight_accept", 64'(acc), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    offer(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, dummy, 1'b1, acc);
    chk("post_rst_accept", 64'(acc), 64'd1);
    offer(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, dummy, 1'b0, acc);
    wait_drain("post_rst_drain");
    repeat (10) @(negedge clk);

    // WIDTH=8, STAGES=1: single registered adder
    @(negedge clk);
    v8_iv = 1'b1; v8_a = 8'hFF; v8_b = 8'h01; v8_ci = 1'b0; v8_sub = 1'b0;
    #1;
    chk("v8_in_ready", 64'(v8_ir), 64'd1);
    @(negedge clk);
    v8_a = 8'h10; v8_b = 8'h20; v8_sub = 1'b1;
    #1;
    chk("v8_valid_lat1", 64'(v8_ov), 64'd1);
    chk("v8_sum_ff_01", 64'(v8_s), 64'h00);
    chk("v8_cout_ff_01", 64'(v8_co), 64'd1);
    chk("v8_of_ff_01", 64'(v8_of), 64'd0);
    @(negedge clk);
    v8_iv = 1'b0;
    #1;
    chk("v8_sum_10_m_20", 64'(v8_s), 64'hF0);
    chk("v8_cout_10_m_20", 64'(v8_co), 64'd0);
    @(negedge clk);
    chk("v8_idle_valid", 64'(v8_ov), 64'd0);

    // WIDTH=16, STAGES=16: one bit per stage
    @(negedge clk);
    w16_iv = 1'b1; w16_a = 16'h7FFF; w16_b = 16'h0001; w16_ci = 1'b0; w16_sub = 1'b0;
    @(negedge clk);
    w16_iv = 1'b0;
    n = 1;
    while (!w16_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w16_latency", 64'(n), 64'd16);
    chk("w16_sum", 64'(w16_s), 64'h8000);
    chk("w16_of", 64'(w16_of), 64'd1);
    chk("w16_cout", 64'(w16_co), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
